// File: rtl/line_bank_writer_if.sv
// Bus bundle between the pixel source/reader side (master) and line_bank_writer (slave).
// in_sof exists only when LINE_BANK_WRITER_SOF_EN is defined.
interface line_bank_writer_if #(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 8
);
    logic               in_valid;
    logic [DATA_WD-1:0] in_data;
    logic               in_ready;
    logic               row_release;
`ifdef LINE_BANK_WRITER_SOF_EN
    logic               in_sof;
`endif
    logic               ram0_we;
    logic               ram1_we;
    logic               ram2_we;
    logic [ADDR_WD-1:0] wr_addr;
    logic [DATA_WD-1:0] wr_data;
    logic [1:0]         wr_bank;
    logic [1:0]         rows_avail;
    logic               row_done;
    logic               frame_done;

`ifdef LINE_BANK_WRITER_SOF_EN
    modport master (
        output in_valid, in_data, in_sof, row_release,
        input  in_ready, ram0_we, ram1_we, ram2_we, wr_addr, wr_data,
               wr_bank, rows_avail, row_done, frame_done
    );
    modport slave (
        input  in_valid, in_data, in_sof, row_release,
        output in_ready, ram0_we, ram1_we, ram2_we, wr_addr, wr_data,
               wr_bank, rows_avail, row_done, frame_done
    );
`else
    modport master (
        output in_valid, in_data, row_release,
        input  in_ready, ram0_we, ram1_we, ram2_we, wr_addr, wr_data,
               wr_bank, rows_avail, row_done, frame_done
    );
    modport slave (
        input  in_valid, in_data, row_release,
        output in_ready, ram0_we, ram1_we, ram2_we, wr_addr, wr_data,
               wr_bank, rows_avail, row_done, frame_done
    );
`endif
endinterface

// File: rtl/line_bank_writer.sv
// Writes a pixel stream row-by-row into three rotating line banks with reader back-pressure.
// Optional feature: LINE_BANK_WRITER_SOF_EN adds in_sof to realign col/row on a start-of-frame beat.
module line_bank_writer #(
    parameter int DATA_WD = 8,
    parameter int IMG_W   = 214,
    parameter int IMG_H   = 120,
    parameter int ADDR_WD = 8
) (
    input logic              clk,
    input logic              rst_n,
    line_bank_writer_if.slave bus
);

    localparam int ROW_WD = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_WD-1:0] LAST_COL = ADDR_WD'(IMG_W - 1);
    localparam logic [ROW_WD-1:0]  LAST_ROW = ROW_WD'(IMG_H - 1);

    typedef enum logic {FILL, STALL} state_t;

    state_t             state;
    logic [ADDR_WD-1:0] col;
    logic [ADDR_WD-1:0] col_eff;
    logic [ROW_WD-1:0]  row;
    logic [ROW_WD-1:0]  row_eff;
    logic [1:0]         bank;
    logic               accept;
    logic               sof;
    logic               last_col;
    logic               last_row;
    logic               dec;
    logic [2:0]         rows_nxt;
    logic [2:0]         commit_nxt;

    assign bus.in_ready = (state == FILL);

    always_comb begin
        accept = bus.in_valid && bus.in_ready;
`ifdef LINE_BANK_WRITER_SOF_EN
        sof = accept && bus.in_sof;
`else
        sof = 1'b0;
`endif
        col_eff  = sof ? '0 : col;
        row_eff  = sof ? '0 : row;
        last_col = (col_eff == LAST_COL);
        last_row = (row_eff == LAST_ROW);
        dec      = bus.row_release && (bus.rows_avail != 2'd0);
        rows_nxt = {1'b0, bus.rows_avail} + {2'b00, bus.row_done} - {2'b00, dec};
        // Count the row being completed this edge too, so the stall lands before a 4th row can start.
        commit_nxt = rows_nxt + {2'b00, accept && last_col};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FILL;
            col            <= '0;
            row            <= '0;
            bank           <= 2'd0;
            bus.rows_avail <= 2'd0;
            bus.ram0_we    <= 1'b0;
            bus.ram1_we    <= 1'b0;
            bus.ram2_we    <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.wr_bank    <= 2'd0;
            bus.row_done   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.ram0_we    <= accept && (bank == 2'd0);
            bus.ram1_we    <= accept && (bank == 2'd1);
            bus.ram2_we    <= accept && (bank == 2'd2);
            bus.row_done   <= accept && last_col;
            bus.frame_done <= accept && last_col && last_row;
            bus.rows_avail <= rows_nxt[1:0];
            state          <= (commit_nxt >= 3'd3) ? STALL : FILL;
            if (accept) begin
                bus.wr_addr <= col_eff;
                bus.wr_data <= bus.in_data;
                bus.wr_bank <= bank;
                if (last_col) begin
                    col  <= '0;
                    bank <= (bank == 2'd2) ? 2'd0 : bank + 2'd1;
                    row  <= last_row ? '0 : row_eff + 1'b1;
                end else begin
                    col  <= col_eff + 1'b1;
                    row  <= row_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_bank_writer.sv
// Directed scoreboard bench for line_bank_writer with IMG_W=4, IMG_H=3.
// Define LINE_BANK_WRITER_SOF_EN to also exercise the start-of-frame realignment.
module tb_line_bank_writer;

    localparam int DATA_WD = 8;
    localparam int ADDR_WD = 8;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;

    typedef struct {
        logic [1:0] bank;
        logic [7:0] addr;
        logic [7:0] data;
        logic       rd;
        logic       fd;
    } expect_t;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   write_cnt = 0;
    int   frame_cnt = 0;
    int   rd_cnt = 0;
    int   m_col = 0;
    int   m_row = 0;
    int   m_bank = 0;
    expect_t exp_q[$];

    line_bank_writer_if #(.DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD)) bus ();

    line_bank_writer #(
        .DATA_WD(DATA_WD),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_WD(ADDR_WD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of bank/column/row sequencing, advanced once per accepted beat.
    task automatic push_expect(input logic [7:0] d, input logic sof);
        expect_t e;
        if (sof) begin
            m_col = 0;
            m_row = 0;
        end
        e.bank = m_bank[1:0];
        e.addr = m_col[7:0];
        e.data = d;
        e.rd   = (m_col == IMG_W - 1);
        e.fd   = e.rd && (m_row == IMG_H - 1);
        if (e.rd) begin
            m_col  = 0;
            m_bank = (m_bank + 1) % 3;
            m_row  = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic sof);
        logic ok;
        logic rdy;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef LINE_BANK_WRITER_SOF_EN
        bus.in_sof   = sof;
`endif
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
        end
        #1;
        bus.in_valid = 1'b0;
`ifdef LINE_BANK_WRITER_SOF_EN
        bus.in_sof   = 1'b0;
`endif
        if (ok) push_expect(d, sof);
        check_output("beat_accepted", ok, 1);
    endtask

    task automatic wait_row_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = bus.row_done;
        end
        check_output("row_done_wait", seen, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_col  = 0;
        m_row  = 0;
        m_bank = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            int nwe;
            nwe = int'(bus.ram0_we) + int'(bus.ram1_we) + int'(bus.ram2_we);
            if (nwe != 0) begin
                write_cnt++;
                if (bus.frame_done) frame_cnt++;
                if (bus.row_done) rd_cnt++;
                check_output("we_onehot", nwe, 1);
                check_output("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    expect_t e;
                    logic [1:0] we_bank;
                    e = exp_q.pop_front();
                    we_bank = bus.ram1_we ? 2'd1 : (bus.ram2_we ? 2'd2 : 2'd0);
                    check_output("we_bank", we_bank, e.bank);
                    check_output("wr_bank", bus.wr_bank, e.bank);
                    check_output("wr_addr", bus.wr_addr, e.addr);
                    check_output("wr_data", bus.wr_data, e.data);
                    check_output("row_done", bus.row_done, e.rd);
                    check_output("frame_done", bus.frame_done, e.fd);
                end
            end else begin
                check_output("pulse_idle", {bus.row_done, bus.frame_done}, 0);
            end
        end
    end

    initial begin
        int w0;
        int f0;
        int r0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.row_release = 1'b0;
`ifdef LINE_BANK_WRITER_SOF_EN
        bus.in_sof      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", bus.in_ready, 1);
        check_output("rst_rows_avail", bus.rows_avail, 0);
        check_output("rst_we", {bus.ram0_we, bus.ram1_we, bus.ram2_we}, 0);
        check_output("rst_wr_addr", bus.wr_addr, 0);
        check_output("rst_wr_bank", bus.wr_bank, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full frame back-to-back with a release one cycle after each row_done.
        w0 = write_cnt;
        f0 = frame_cnt;
        fork
            begin
                for (int i = 0; i < 12; i++) apply_stimulus(8'(i), 1'b0);
            end
            begin
                for (int r = 0; r < 3; r++) begin
                    wait_row_done();
                    @(negedge clk);
                    bus.row_release = 1'b1;
                    @(negedge clk);
                    bus.row_release = 1'b0;
                end
            end
        join
        repeat (3) @(negedge clk);
        check_output("frame_writes", write_cnt - w0, 12);
        check_output("frame_done_once", frame_cnt - f0, 1);
        check_output("frame_rows_avail", bus.rows_avail, 0);
        check_output("frame_in_ready", bus.in_ready, 1);

        // Three unreleased rows stall the 13th beat until a release.
        do_reset();
        for (int i = 0; i < 12; i++) apply_stimulus(8'(8'h40 + i), 1'b0);
        @(negedge clk);
        check_output("stall_ready_fall", bus.in_ready, 0);
        fork
            apply_stimulus(8'h4C, 1'b0);
            begin
                repeat (4) @(negedge clk);
                check_output("stall_rows_avail", bus.rows_avail, 3);
                check_output("stall_held", bus.in_ready, 0);
                check_output("stall_no_extra_write", exp_q.size(), 0);
                bus.row_release = 1'b1;
                @(negedge clk);
                bus.row_release = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check_output("stall_after_release", bus.rows_avail, 2);

        // Release coinciding with the 2->3 increment keeps rows_avail at 2.
        do_reset();
        for (int i = 0; i < 12; i++) apply_stimulus(8'(8'h80 + i), 1'b0);
        bus.row_release = 1'b1;
        @(negedge clk);
        check_output("coinc_row_done", bus.row_done, 1);
        check_output("coinc_rows_before", bus.rows_avail, 2);
        @(posedge clk);
        #1;
        bus.row_release = 1'b0;
        @(negedge clk);
        check_output("coinc_rows_after", bus.rows_avail, 2);
        check_output("coinc_in_ready", bus.in_ready, 1);

        // Asynchronous reset mid-row clears outputs immediately and discards the partial row.
        do_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(8'(8'h10 + i), 1'b0);
        check_output("pre_reset_rows", bus.rows_avail, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("arst_we", {bus.ram0_we, bus.ram1_we, bus.ram2_we}, 0);
        check_output("arst_wr_data", bus.wr_data, 0);
        check_output("arst_wr_addr", bus.wr_addr, 0);
        check_output("arst_wr_bank", bus.wr_bank, 0);
        check_output("arst_rows_avail", bus.rows_avail, 0);
        check_output("arst_pulses", {bus.row_done, bus.frame_done}, 0);
        m_col  = 0;
        m_row  = 0;
        m_bank = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(8'h55, 1'b0);

        // Gapped valid: one write per accepted beat, contiguous addresses.
        do_reset();
        w0 = write_cnt;
        apply_stimulus(8'hA0, 1'b0);
        @(posedge clk);
        #1;
        apply_stimulus(8'hA1, 1'b0);
        @(posedge clk);
        #1;
        apply_stimulus(8'hA2, 1'b0);
        @(posedge clk);
        #1;
        apply_stimulus(8'hA3, 1'b0);
        repeat (3) @(negedge clk);
        check_output("gap_writes", write_cnt - w0, 4);

`ifdef LINE_BANK_WRITER_SOF_EN
        // SOF on the 3rd beat of row 1 restarts at addr 0 in the same bank.
        do_reset();
        r0 = rd_cnt;
        for (int i = 0; i < 6; i++) apply_stimulus(8'(8'h20 + i), 1'b0);
        apply_stimulus(8'h26, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(8'(8'h27 + i), 1'b0);
        repeat (3) @(negedge clk);
        check_output("sof_row_done_count", rd_cnt - r0, 2);
`else
        r0 = rd_cnt;
`endif

        repeat (2) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_bank_writer.md
LINE_BANK_WRITER -- requirements
Module: line_bank_writer

Interface
REQ-001 SHALL have parameter DATA_WD, default 8, pixel width.
REQ-002 SHALL have parameter IMG_W, default 214, pixels per row.
REQ-003 SHALL have parameter IMG_H, default 120, rows per frame.
REQ-004 SHALL have parameter ADDR_WD, default 8, column address width, with IMG_W <= 2**ADDR_WD.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, pixel beat offered.
REQ-008 SHALL have port in_data, input, DATA_WD, pixel value.
REQ-009 SHALL have port in_ready, output, 1, writer accepts a beat; a beat transfers when in_valid && in_ready.
REQ-010 SHALL have port row_release, input, 1, one-cycle pulse from the reader freeing the oldest buffered row.
REQ-011 SHALL have ports ram0_we, ram1_we, ram2_we, output, 1 each, write enables for banks 0/1/2.
REQ-012 SHALL have port wr_addr, output, ADDR_WD, column address of the write.
REQ-013 SHALL have port wr_data, output, DATA_WD, data written.
REQ-014 SHALL have port wr_bank, output, 2, bank of the current write (0..2).
REQ-015 SHALL have port rows_avail, output, 2, count of complete unreleased rows (0..3).
REQ-016 SHALL have port row_done, output, 1, pulse on the last-column write of a row.
REQ-017 SHALL have port frame_done, output, 1, pulse on the last-column write of row IMG_H-1.

Function
REQ-018 SHALL write row r of the stream into bank (r mod 3), with the bank pointer free-running across frames.
REQ-019 SHALL register all write outputs, so a beat accepted at edge N drives exactly one we, wr_addr=col, wr_data and wr_bank in cycle N+1.
REQ-020 SHALL hold all three we low in any cycle with no accepted beat at the prior edge.
REQ-021 SHALL increment the column counter per accepted beat; at IMG_W-1 it SHALL wrap to 0, advance the bank (2->0), and advance the row counter.
REQ-022 SHALL wrap the row counter to 0 after row IMG_H-1, pulsing frame_done together with row_done.
REQ-023 SHALL implement states FILL (in_ready=1) and STALL (in_ready=0); FILL->STALL when rows_avail reaches 3; STALL->FILL on the edge row_release is sampled.
REQ-024 SHALL increment rows_avail one cycle after row_done and decrement it on each sampled row_release.
REQ-025 SHALL leave rows_avail unchanged when an increment and a decrement coincide.
REQ-026 SHALL ignore row_release when rows_avail is 0.
REQ-027 SHALL accept no beat while in_ready is 0; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear col, row, bank, rows_avail, all we, wr_addr, wr_data, wr_bank, row_done and frame_done to 0 and enter FILL.
REQ-029 SHALL, on reset asserted mid-row, discard the partial row, with the first post-reset beat written to bank 0, address 0.

Configuration
REQ-030 SHALL, when LINE_BANK_WRITER_SOF_EN is defined, add input in_sof (1 bit); an accepted beat with in_sof=1 SHALL reset col and row to 0 before its write, be written at address 0, and keep the bank pointer unchanged so any partial row is overwritten.
REQ-031 SHALL, when LINE_BANK_WRITER_SOF_EN is not defined, have no in_sof port and align frames by counters only.

Verification (IMG_W=4, IMG_H=3)
REQ-032 SHALL verify: 12 back-to-back beats 0x00..0x0B with row_release pulsed after each row_done -> bank0 addr0..3 = 00..03, bank1 = 04..07, bank2 = 08..0B; frame_done once, with data 0x0B.
REQ-033 SHALL verify: 13 beats with no row_release -> in_ready falls after the 12th write; the 13th beat stalls; one row_release -> it is written to bank0 addr0.
REQ-034 SHALL verify: row_release in the same cycle rows_avail would increment from 2 -> rows_avail stays 2.
REQ-035 SHALL verify: rst_n low after 6 beats -> all outputs 0 immediately; the next beat is written to bank0 addr0.
REQ-036 SHALL verify: in_valid toggling 1,0,1,0 -> exactly one we per accepted beat, with addresses contiguous.
REQ-037 SHALL verify, with LINE_BANK_WRITER_SOF_EN defined: in_sof on the 3rd beat of row 1 -> that beat is written to bank1 addr0, and row_done does not fire for the abandoned partial row.
